// File: rtl/instr_fetch.sv
// instr_fetch: writable instruction memory, program counter, issue control and an output FIFO toward decode.
// Optional build macro IFETCH_HALT_ON_ZERO_EN: an all-zero fetched word halts issue until redirect or reset.
module instr_fetch #(
    parameter int  INSTR_W    = 12,
    parameter int  DEPTH      = 8,
    parameter int  FIFO_DEPTH = 2,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               halted
);
    localparam int               CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

    logic [INSTR_W-1:0] mem_r     [DEPTH];
    logic [INSTR_W-1:0] q_instr_r [FIFO_DEPTH];
    logic [INSTR_W-1:0] q_instr_s [FIFO_DEPTH];
    logic [ADDR_W-1:0]  q_pc_r    [FIFO_DEPTH];
    logic [ADDR_W-1:0]  q_pc_s    [FIFO_DEPTH];
    logic [ADDR_W-1:0]  pc_r, pc_s;
    logic [CNT_W-1:0]   count_r, count_s, kept_s;
    logic               valid_r, halted_r, halted_s;
    logic [INSTR_W-1:0] word_s;
    logic               pop_s, issue_s, zero_hit_s, push_s;

    // Program memory: write port only, no reset so a loaded program survives reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_r[prog_addr] <= prog_data;
        end
    end

    // Issue decision; a same-cycle pop frees a slot, so a full FIFO can still accept.
    always_comb begin
        word_s  = mem_r[pc_r];
        pop_s   = valid_r & instr_ready;
        kept_s  = count_r - CNT_W'(pop_s);
        issue_s = en & ~halted_r & ~redirect_valid & (kept_s < FIFO_FULL);
`ifdef IFETCH_HALT_ON_ZERO_EN
        zero_hit_s = issue_s & (word_s == {INSTR_W{1'b0}});
`else
        zero_hit_s = 1'b0;
`endif
        push_s = issue_s & ~zero_hit_s;
    end

    // Next-state: redirect flushes and reloads PC; otherwise shift-on-pop then append at the tail.
    always_comb begin
        pc_s      = pc_r;
        halted_s  = halted_r;
        count_s   = count_r;
        q_instr_s = q_instr_r;
        q_pc_s    = q_pc_r;
        if (redirect_valid) begin
            pc_s     = redirect_addr;
            halted_s = 1'b0;
            count_s  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                pc_s = pc_r + ADDR_W'(1);
            end else begin
                pc_s = pc_r;
            end
            if (zero_hit_s) begin
                halted_s = 1'b1;
            end else begin
                halted_s = halted_r;
            end
            count_s = kept_s + CNT_W'(push_s);
            // Slot 0 only changes when real data lands in it, so the head holds its last value when empty.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (push_s && (kept_s == CNT_W'(i))) begin
                    q_instr_s[i] = word_s;
                    q_pc_s[i]    = pc_r;
                end else if (pop_s && (CNT_W'(i + 1) < count_r)) begin
                    q_instr_s[i] = q_instr_r[(i + 1) % FIFO_DEPTH];
                    q_pc_s[i]    = q_pc_r[(i + 1) % FIFO_DEPTH];
                end else begin
                    q_instr_s[i] = q_instr_r[i];
                    q_pc_s[i]    = q_pc_r[i];
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r     <= {ADDR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_instr_r[i] <= {INSTR_W{1'b0}};
                q_pc_r[i]    <= {ADDR_W{1'b0}};
            end
        end else begin
            pc_r      <= pc_s;
            count_r   <= count_s;
            valid_r   <= (count_s != {CNT_W{1'b0}});
            halted_r  <= halted_s;
            q_instr_r <= q_instr_s;
            q_pc_r    <= q_pc_s;
        end
    end

    assign instr_valid = valid_r;
    assign instr       = q_instr_r[0];
    assign instr_pc    = q_pc_r[0];
    assign halted      = halted_r;

endmodule
